// File: rtl/ps2_keyb_ctrl.sv
// PS/2 keyboard receiver with scancode FIFO, bus-mapped data/status registers and toggle IRQ.
// Optional odd-parity checking is enabled by defining KEYB_PARITY_EN.
module ps2_keyb_ctrl #(
  parameter logic [15:0] Base      = 16'hFF00,
  parameter int unsigned DepthLog2 = 4,
  parameter int unsigned Filter    = 8,
  parameter int unsigned Timeout   = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  input  logic [15:0] addr_i,
  input  logic        wren_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic        hit_o,
  output logic        irq_keyb_o
);

  localparam int unsigned Depth  = 2 ** DepthLog2;
  localparam int unsigned CntW   = DepthLog2 + 1;
  localparam int unsigned FiltW  = $clog2(Filter + 1);
  localparam int unsigned TimeW  = $clog2(Timeout + 1);
  localparam logic [15:0] StatAddr = Base + 16'd1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q, fall_q;
  logic [FiltW-1:0] fcnt_q;

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic [TimeW-1:0] to_cnt_q, to_cnt_d;
  logic             push_req, set_ferr, set_perr;

  logic [7:0]           mem_q [Depth];
  logic [DepthLog2-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]      count_q;
  logic                 ferr_q, perr_q, ovf_q, irq_q;
  logic [7:0]           rdata_q, rdata_d;
  logic                 hit_q, hit_d;
  logic                 empty, full, pop_req, stat_wr, do_pop, do_push, set_ovf;
  logic                 dat_s;

  assign dat_s = dat_sync_q[1];

  // Level filter: the synchronised clock must differ from the accepted level for Filter cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FiltW'(Filter - 1)) begin
        fcnt_q <= '0;
        filt_q <= clk_sync_q[1];
        fall_q <= filt_q;
      end else begin
        fcnt_q <= fcnt_q + FiltW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    to_cnt_d  = '0;
    push_req  = 1'b0;
    set_ferr  = 1'b0;
    set_perr  = 1'b0;
    if (state_q != StIdle && !fall_q) begin
      to_cnt_d = to_cnt_q + TimeW'(1);
      if (to_cnt_q == TimeW'(Timeout - 1)) begin
        state_d  = StIdle;
        to_cnt_d = '0;
      end
    end else if (fall_q) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
            par_bad_d = 1'b0;
          end
        end
        StData: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
`ifdef KEYB_PARITY_EN
          if (!(^{shift_q, dat_s})) begin
            par_bad_d = 1'b1;
            set_perr  = 1'b1;
          end
`endif
          state_d = StStop;
        end
        StStop: begin
          if (dat_s) push_req = !par_bad_q;
          else       set_ferr = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign pop_req = wren_i && (addr_i == Base);
  assign stat_wr = wren_i && (addr_i == StatAddr);
  assign do_pop  = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_req && (!full || do_pop);
  assign set_ovf = push_req && full && !do_pop;

  always_comb begin
    rdata_d = 8'h00;
    hit_d   = 1'b0;
    if (addr_i == Base) begin
      hit_d   = 1'b1;
      rdata_d = empty ? 8'h00 : mem_q[rptr_q];
    end else if (addr_i == StatAddr) begin
      hit_d   = 1'b1;
      rdata_d = {4'b0, ferr_q, perr_q, ovf_q, !empty};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      to_cnt_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= 8'h00;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      to_cnt_q  <= to_cnt_d;
      if (do_push) wptr_q <= wptr_q + DepthLog2'(1);
      if (do_pop)  rptr_q <= rptr_q + DepthLog2'(1);
      count_q   <= count_q + CntW'(do_push) - CntW'(do_pop);
      ferr_q    <= (ferr_q & ~(stat_wr & wdata_i[3])) | set_ferr;
      ovf_q     <= (ovf_q & ~(stat_wr & wdata_i[1])) | set_ovf;
      irq_q     <= irq_q ^ do_push;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
    end
  end

`ifdef KEYB_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) perr_q <= 1'b0;
    else       perr_q <= (perr_q & ~(stat_wr & wdata_i[2])) | set_perr;
  end
  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[7:4], wdata_i[0]};
`else
  assign perr_q = 1'b0;
  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[7:4], wdata_i[2], wdata_i[0], set_perr};
`endif

  assign rdata_o    = rdata_q;
  assign hit_o      = hit_q;
  assign irq_keyb_o = irq_q;

endmodule

// File: tb/tb_ps2_keyb_ctrl.sv
// Self-checking bench for ps2_keyb_ctrl: random PS/2 frames against a queue-based model.
module tb_ps2_keyb_ctrl;
  localparam logic [15:0] Base = 16'hFF00;
  localparam int Hp = 30;
  localparam int To = 400;
`ifdef KEYB_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, ps2c = 1'b1, ps2d = 1'b1, wren = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0] wdata = 8'h00, rdata;
  logic hit, irq;

  always #5 clk = ~clk;

  ps2_keyb_ctrl #(.Base(Base), .DepthLog2(4), .Filter(8), .Timeout(To)) dut (
    .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2c), .ps2_dat_i(ps2d), .addr_i(addr),
    .wren_i(wren), .wdata_i(wdata), .rdata_o(rdata), .hit_o(hit), .irq_keyb_o(irq)
  );

  int nerr = 0, nchk = 0, lat = 0;
  byte unsigned mq[$];
  bit m_ovf = 0, m_perr = 0, m_ferr = 0, m_irq = 0;
  logic [7:0] rd;
  logic hd;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0, m_ferr, m_perr, m_ovf, mq.size() != 0};
  endfunction

  task automatic model_frame(input logic [7:0] d, input bit par, input bit stop, input bit pop);
    bit bad;
    bad = ParEn && ((^{d, par}) == 1'b0);
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (bad) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    else if (!bad) begin
      if (mq.size() >= 16) m_ovf = 1'b1;
      else begin
        mq.push_back(d);
        m_irq = ~m_irq;
      end
    end
  endtask

  task automatic ps2_bit(input bit b, input bit pop, input bit meas);
    logic i0;
    @(negedge clk) ps2d = b;
    repeat (Hp) @(negedge clk);
    ps2c = 1'b0;
    i0 = irq;
    fork
      begin repeat (Hp) @(negedge clk); end
      begin
        if (pop && lat > 1) begin
          repeat (lat - 1) @(posedge clk);
          @(negedge clk);
          addr = Base; wren = 1'b1; wdata = 8'($urandom);
          @(posedge clk);
          @(negedge clk);
          wren = 1'b0; addr = 16'h0000;
        end
      end
      begin
        if (meas) begin
          for (int k = 1; k < Hp - 1; k++) begin
            @(posedge clk); #1;
            if (irq !== i0) begin lat = k; break; end
          end
        end
      end
    join
    ps2c = 1'b1;
  endtask

  // nbits < 8 sends only start plus that many data bits (abandoned frame).
  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int nbits,
                            input bit pop, input bit meas);
    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0, 1'b0);
    if (nbits == 8) begin
      ps2_bit(par, 1'b0, 1'b0);
      ps2_bit(stop, pop, meas);
    end
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
    if (nbits == 8) model_frame(d, par, stop, pop);
  endtask

  task automatic read_reg(input logic [15:0] a);
    @(negedge clk) addr = a;
    @(posedge clk); #1;
    rd = rdata; hd = hit;
    @(negedge clk) addr = 16'h0000;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk) begin addr = a; wren = 1'b1; wdata = v; end
    @(negedge clk) begin wren = 1'b0; addr = 16'h0000; end
  endtask

  task automatic chk_status(input string tag);
    read_reg(Base + 16'd1);
    check(tag, rd, m_status());
    check({tag, "_hit"}, {7'b0, hd}, 8'h01);
  endtask

  task automatic chk_pop(input string tag);
    read_reg(Base);
    check(tag, rd, (mq.size() > 0) ? mq[0] : 8'h00);
    write_reg(Base, 8'($urandom));
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    write_reg(Base + 16'd1, 8'h0E);
    m_ferr = 1'b0; m_ovf = 1'b0;
    if (ParEn) m_perr = 1'b0;
  endtask

  function automatic bit odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    logic [7:0] d;
    bit pbit, sbit;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_hit", {7'b0, hit}, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;
    chk_status("rst_status");
    read_reg(16'h1234);
    check("other_rdata", rd, 8'h00);
    check("other_hit", {7'b0, hd}, 8'h00);

    // Single good frame, also measures push latency for the concurrent-pop test.
    send_frame(8'h1C, 1'b0, 1'b1, 8, 1'b0, 1'b1);
    check("f1_irq", {7'b0, irq}, {7'b0, m_irq});
    check("lat_found", {7'b0, (lat >= 3 && lat <= 25)}, 8'h01);
    chk_status("f1_status");
    chk_pop("f1_head");
    chk_status("f1_empty");

    // 17 frames into a 16-entry FIFO.
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      send_frame(d, odd_par(d), 1'b1, 8, 1'b0, 1'b0);
    end
    check("ovf_irq", {7'b0, irq}, {7'b0, m_irq});
    chk_status("ovf_status");
    write_reg(Base + 16'd1, 8'h02);
    m_ovf = 1'b0;
    chk_status("ovf_clr");

    // Push coincident with pop while full.
    d = 8'($urandom);
    send_frame(d, odd_par(d), 1'b1, 8, 1'b1, 1'b0);
    chk_status("pp_status");
    check("pp_irq", {7'b0, irq}, {7'b0, m_irq});
    for (int i = 0; i < 16; i++) chk_pop("drain");
    chk_status("drain_empty");
    write_reg(Base, 8'hFF);
    chk_status("pop_empty");
    read_reg(Base);
    check("pop_empty_head", rd, 8'h00);

    // Bad parity.
    send_frame(8'h1C, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    chk_status("par_status");
    check("par_irq", {7'b0, irq}, {7'b0, m_irq});
    while (mq.size() > 0) chk_pop("par_head");
    clear_flags();

    // Bad stop bit.
    send_frame(8'h1C, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    chk_status("ferr_status");
    check("ferr_irq", {7'b0, irq}, {7'b0, m_irq});
    clear_flags();
    chk_status("ferr_clr");

    // Abandoned frame followed by timeout, then a good frame.
    send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    repeat (To + 50) @(negedge clk);
    chk_status("to_status");
    send_frame(8'hF0, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    chk_status("to_next_status");
    chk_pop("to_next_head");

    // Random mix of good and corrupted frames.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      sbit = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, sbit, 8, 1'b0, 1'b0);
      chk_status("rnd_status");
      check("rnd_irq", {7'b0, irq}, {7'b0, m_irq});
      chk_pop("rnd_head");
      clear_flags();
    end

    // Reset with 3 bytes queued and a partial frame in flight.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(d, odd_par(d), 1'b1, 8, 1'b0, 1'b0);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_irq = 1'b0;
    #1;
    check("rst2_rdata", rdata, 8'h00);
    check("rst2_irq", {7'b0, irq}, 8'h00);
    chk_status("rst2_status");
    d = 8'($urandom);
    send_frame(d, odd_par(d), 1'b1, 8, 1'b0, 1'b0);
    check("rst2_irq_after", {7'b0, irq}, {7'b0, m_irq});
    chk_status("rst2_next_status");
    chk_pop("rst2_next_head");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
